// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32 constants: datapath width, canonical NOP,
//                major opcodes and instruction field positions.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   // addi x0, x0, 0
   localparam word_t NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   // Instruction field bit positions
   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_MSB = 31;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Small synchronous FIFO with flush. When empty, a pushed word
//                is visible at the head in the same cycle (fall-through), and
//                a simultaneous push+pop on an empty queue passes straight
//                through without being stored.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic                       o_valid,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_bypass;
   logic w_wr_en;
   logic w_rd_en;

   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
   endfunction

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == c_CNT_W'(DEPTH));
   // Push and pop on an empty queue: the word is consumed without storage
   assign w_bypass = w_empty && i_push && i_pop;
   assign w_wr_en  = i_push && !w_bypass && (!w_full || i_pop);
   assign w_rd_en  = i_pop && !w_empty;

   assign o_valid  = !w_empty || i_push;
   assign o_data   = w_empty ? i_data : r_mem[r_rd_ptr];
   assign o_count  = r_count;

   // Pointer and occupancy bookkeeping; flush discards every entry at once
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_rd_en) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_wr_en && !w_rd_en) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (!w_wr_en && w_rd_en) begin
            r_count <= r_count - c_CNT_W'(1);
         end
      end
   end

   // Entry storage; contents are only observed once counted, so no reset
   always_ff @(posedge clk) begin
      if (w_wr_en && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_stage
//  Description : Owns the PC, issues word reads over req/gnt + rvalid,
//                buffers returned words in order and hands them to decode
//                with valid/ready, pre-split into opcode/funct3/funct7.
//                Redirects flush all wrong-path work; responses still in
//                flight for the old path are counted and dropped on return.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_stage #(
   parameter int                       XLEN     = riscv_pkg::XLEN,
   parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = '0,
   parameter int                       FQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7
);

   import riscv_pkg::*;

   localparam int c_CNT_W   = $clog2(FQ_DEPTH + 1);
   localparam int c_SUM_W   = c_CNT_W + 1;
   localparam int c_ENTRY_W = 2 * XLEN;

   logic [XLEN-1:0]    r_fetch_pc;
   logic [c_CNT_W-1:0] r_discard;

   logic               w_addr_valid;
   logic [XLEN-1:0]    w_addr_head;
   logic [c_CNT_W-1:0] w_addr_count;
   logic               w_addr_known;
   logic               w_addr_pop;

   logic               w_q_valid;
   logic [c_ENTRY_W-1:0] w_q_head;
   logic [c_CNT_W-1:0] w_q_count;
   logic               w_q_push;
   logic               w_q_pop;

   logic [c_SUM_W-1:0] w_outstanding;
   logic [c_SUM_W-1:0] w_inflight;
   logic               w_issue;
   logic               w_resp_any;
   logic               w_resp_live;
   logic [XLEN-1:0]    w_redirect_aligned;

   // Every issued request lives either in the address FIFO (live path) or in
   // the discard counter (flushed path), so their sum is the outstanding count.
   assign w_outstanding = c_SUM_W'(w_addr_count) + c_SUM_W'(r_discard);
   assign w_inflight    = w_outstanding + c_SUM_W'(w_q_count);

   // Credit: never have more words requested or buffered than queue slots
   assign imem_req  = !rst && !redirect_valid && (w_inflight < c_SUM_W'(FQ_DEPTH));
   assign imem_addr = r_fetch_pc;
   assign w_issue   = imem_req && imem_gnt;

   // A response only matches a live request when one was issued earlier;
   // the same-cycle fall-through of a fresh issue is excluded.
   assign w_addr_known = w_addr_valid && (w_addr_count != '0);
   assign w_resp_any   = imem_rvalid && (w_outstanding != '0);
   assign w_resp_live  = imem_rvalid && (r_discard == '0) && w_addr_known;
   assign w_addr_pop   = w_resp_live && !redirect_valid;
   assign w_q_push     = w_resp_live && !redirect_valid && !rst;

   assign id_valid  = w_q_valid && !redirect_valid && !rst;
   assign w_q_pop   = id_valid && id_ready;
   assign id_instr  = id_valid ? w_q_head[XLEN-1:0] : XLEN'(NOP_INSTR);
   assign id_pc     = id_valid ? w_q_head[c_ENTRY_W-1:XLEN] : RESET_PC;
   assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
   assign id_funct3 = id_instr[FUNCT3_MSB:FUNCT3_LSB];
   assign id_funct7 = id_instr[FUNCT7_MSB:FUNCT7_LSB];

   assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

   // Program counter: reset, redirect, or advance one word per issued request
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_fetch_pc <= w_redirect_aligned;
      end else if (w_issue) begin
         r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
   end

   // Wrong-path responses still to come; a redirect turns every outstanding
   // request into one, less any response that is being dropped right now
   always_ff @(posedge clk) begin
      if (rst) begin
         r_discard <= '0;
      end else if (redirect_valid) begin
         r_discard <= c_CNT_W'(w_outstanding - c_SUM_W'(w_resp_any));
      end else if (imem_rvalid && (r_discard != '0)) begin
         r_discard <= r_discard - c_CNT_W'(1);
      end
   end

   // Address of each live request, popped in order as responses return
   fetch_queue #(
      .WIDTH (XLEN),
      .DEPTH (FQ_DEPTH)
   ) u_addr_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (w_issue),
      .i_data  (r_fetch_pc),
      .i_pop   (w_addr_pop),
      .o_valid (w_addr_valid),
      .o_data  (w_addr_head),
      .o_count (w_addr_count)
   );

   // Returned {pc, instruction} pairs waiting for decode
   fetch_queue #(
      .WIDTH (c_ENTRY_W),
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (w_q_push),
      .i_data  ({w_addr_head, imem_rdata}),
      .i_pop   (w_q_pop),
      .o_valid (w_q_valid),
      .o_data  (w_q_head),
      .o_count (w_q_count)
   );

endmodule
`default_nettype wire
